seg_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller for the Basys3 4-digit seven-segment display.
//  - Shares the single 7-bit segment bus among four anodes in round-robin slots.
//  - Accepts a new 16-bit hex value through a valid/ready handshake, double-buffered so a frame never tears.
//  - Drives the same 11-bit {an[3:0], seg[6:0]} active-low word used by the board's decoder blocks.

---
 rtl/seg_pkg.sv | 22 ++
 rtl/seg7_hex_dec.sv | 14 +
 rtl/seg_scan_ctrl.sv | 116 +++++++++++
 tb/tb_seg_scan_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Segment words are active-low {a..g}; anode words are active-low an[3:0].
package seg_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t      SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'hF;

    localparam seg7_t SEG_HEX [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    typedef enum logic {
        S_GAP   = 1'b0,
        S_DRIVE = 1'b1
    } scan_state_t;

endpackage

// File: rtl/seg7_hex_dec.sv
// Combinational hex nibble to active-low seven-segment lookup with a blanking override.
module seg7_hex_dec
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output seg7_t      seg
);

    always_comb begin
        seg = blank ? SEG_BLANK : SEG_HEX[nibble];
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Round-robin scan controller for a 4-digit seven-segment display with a double-buffered load port.
// Define SEG_SCAN_LZ_BLANK_EN to enable leading-zero suppression on digits 3..1.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV = 100_000,
    parameter int GAP_CYC     = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_valid,
    input  logic [15:0] load_data,
    output logic        load_ready,
    input  logic [3:0]  digit_en,
    output logic [10:0] display_out,
    output logic [1:0]  scan_idx
);

    localparam int               CNT_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_GAP  = CNT_W'(GAP_CYC);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       scan_idx_q, scan_idx_d;
    scan_state_t      state_q, state_d;
    logic [15:0]      shadow_q, shadow_d;
    logic [15:0]      active_q, active_d;
    logic             pending_q, pending_d;
    logic [10:0]      display_q, display_d;

    logic       slot_wrap;
    logic       frame_end;
    logic       xfer;
    logic [3:0] lz_blank;
    logic [3:0] sel_nibble;
    logic       sel_blank;
    seg7_t      seg_lit;

    assign slot_wrap = (cnt_q == CNT_LAST);
    assign frame_end = slot_wrap && (scan_idx_q == 2'd3);
    assign xfer      = load_valid && !pending_q;

    always_comb begin
        cnt_d      = slot_wrap ? '0 : cnt_q + 1'b1;
        scan_idx_d = slot_wrap ? scan_idx_q + 2'd1 : scan_idx_q;
        // State is derived from the next count so state_q always agrees with cnt_q.
        state_d    = (cnt_d < CNT_GAP) ? S_GAP : S_DRIVE;
    end

    // A commit needs pending_q = 1, so it can never coincide with a transfer.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a value unassigned (no latch).
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        if (pending_q && frame_end) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end else if (xfer) begin
            shadow_d  = load_data;
            pending_d = 1'b1;
        end
    end

    always_comb begin
        lz_blank = '0;
`ifdef SEG_SCAN_LZ_BLANK_EN
        lz_blank[3] = (active_q[15:12] == 4'h0);
        lz_blank[2] = lz_blank[3] && (active_q[11:8] == 4'h0);
        lz_blank[1] = lz_blank[2] && (active_q[7:4] == 4'h0);
`endif
    end

    assign sel_nibble = active_q[4*scan_idx_q +: 4];
    assign sel_blank  = !digit_en[scan_idx_q] || lz_blank[scan_idx_q];

    seg7_hex_dec u_dec (
        .nibble (sel_nibble),
        .blank  (sel_blank),
        .seg    (seg_lit)
    );

    // Blanked digits keep their anode on so per-digit on-time stays uniform.
    always_comb begin
        display_d = {AN_OFF, SEG_BLANK};
        if (state_q == S_DRIVE) begin
            display_d = {~(4'b0001 << scan_idx_q), seg_lit};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            scan_idx_q <= 2'd0;
            state_q    <= S_GAP;
            shadow_q   <= 16'h0000;
            active_q   <= 16'h0000;
            pending_q  <= 1'b0;
            display_q  <= {AN_OFF, SEG_BLANK};
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            cnt_q      <= cnt_d;
            scan_idx_q <= scan_idx_d;
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            active_q   <= active_d;
            pending_q  <= pending_d;
            display_q  <= display_d;
        end
    end

    assign load_ready  = !pending_q;
    assign display_out = display_q;
    assign scan_idx    = scan_idx_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with a cycle model feeding a scoreboard queue.
// Honors SEG_SCAN_LZ_BLANK_EN in its expectations when defined.
module tb_seg_scan_ctrl;

    localparam int RDIV = 8;
    localparam int GAP  = 2;

    typedef struct packed {
        logic [10:0] disp;
        logic [1:0]  idx;
        logic        rdy;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_valid = 1'b0;
    logic [15:0] load_data = 16'h0000;
    logic [3:0]  digit_en = 4'hF;
    logic        load_ready;
    logic [10:0] display_out;
    logic [1:0]  scan_idx;

    int n_checks = 0;
    int n_errors = 0;

    int          m_k;
    logic        m_pending;
    logic [15:0] m_shadow;
    logic [15:0] m_active;
    exp_t        sb[$];

    always #5 clk = ~clk;

    seg_scan_ctrl #(
        .REFRESH_DIV (RDIV),
        .GAP_CYC     (GAP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_ready  (load_ready),
        .digit_en    (digit_en),
        .display_out (display_out),
        .scan_idx    (scan_idx)
    );

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: return 7'b0000001;  4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;  4'h3: return 7'b0000110;
            4'h4: return 7'b1001100;  4'h5: return 7'b0100100;
            4'h6: return 7'b0100000;  4'h7: return 7'b0001111;
            4'h8: return 7'b0000000;  4'h9: return 7'b0000100;
            4'hA: return 7'b0001000;  4'hB: return 7'b1100000;
            4'hC: return 7'b0110001;  4'hD: return 7'b1000010;
            4'hE: return 7'b0110000;  default: return 7'b0111000;
        endcase
    endfunction

    function automatic logic lz(input logic [15:0] a, input int i);
`ifdef SEG_SCAN_LZ_BLANK_EN
        if (i == 0) return 1'b0;
        return ((a >> (4 * i)) == 16'h0000);
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_k       = 0;
        m_pending = 1'b0;
        m_shadow  = 16'h0000;
        m_active  = 16'h0000;
    endtask

    // One clock: predict from pre-edge model state and inputs, then compare after the edge.
    task automatic step();
        exp_t e;
        exp_t got;
        int   pos;
        int   idx;
        logic boundary;
        pos = m_k % RDIV;
        idx = (m_k / RDIV) % 4;
        if (pos >= GAP) begin
            e.disp[10:7] = ~(4'b0001 << idx);
            e.disp[6:0]  = (!digit_en[idx] || lz(m_active, idx)) ? 7'h7F : hex7(m_active[4*idx +: 4]);
        end else begin
            e.disp = 11'h7FF;
        end
        boundary = (pos == RDIV - 1) && (idx == 3);
        if (m_pending && boundary) begin
            m_active  = m_shadow;
            m_pending = 1'b0;
        end else if (load_valid && !m_pending) begin
            m_shadow  = load_data;
            m_pending = 1'b1;
        end
        m_k++;
        e.idx = 2'((m_k / RDIV) % 4);
        e.rdy = !m_pending;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check("display", {5'd0, display_out}, {5'd0, got.disp});
        check("scan_idx", {14'd0, scan_idx}, {14'd0, got.idx});
        check("load_ready", {15'd0, load_ready}, {15'd0, got.rdy});
    endtask

    task automatic run_to(input int t);
        while (m_k < t) step();
    endtask

    initial begin
        model_reset();
        repeat (3) begin
            @(posedge clk);
            #1;
            check("rst_display", {5'd0, display_out}, 16'h07FF);
            check("rst_scan_idx", {14'd0, scan_idx}, 16'h0000);
            check("rst_ready", {15'd0, load_ready}, 16'h0001);
        end
        @(negedge clk);
        rst = 1'b0;

        // Commit a value, leave another pending, then reset mid-scan.
        load_valid = 1'b1;
        load_data  = 16'h9999;
        step();
        load_valid = 1'b0;
        run_to(40);
        check("pre_rst_digit0", {5'd0, display_out}, {5'd0, 11'b1110_0000100});
        load_valid = 1'b1;
        load_data  = 16'h3333;
        step();
        load_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("midrst_display", {5'd0, display_out}, 16'h07FF);
        check("midrst_scan_idx", {14'd0, scan_idx}, 16'h0000);
        check("midrst_ready", {15'd0, load_ready}, 16'h0001);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Load 1234, then hold ABCD while the first value is still pending.
        load_valid = 1'b1;
        load_data  = 16'h1234;
        step();
        load_data  = 16'hABCD;
        run_to(3);
        check("f0_digit0_zero", {5'd0, display_out}, {5'd0, 11'b1110_0000001});
        run_to(31);
        check("held_ready_low", {15'd0, load_ready}, 16'h0000);
        step();
        check("ready_after_commit", {15'd0, load_ready}, 16'h0001);
        step();
        load_valid = 1'b0;
        check("abcd_accepted", {15'd0, load_ready}, 16'h0000);
        run_to(35);
        check("f1_digit0_4", {5'd0, display_out}, {5'd0, 11'b1110_1001100});
        run_to(59);
        check("f1_digit3_1", {5'd0, display_out}, {5'd0, 11'b0111_1001111});
        run_to(64);
        check("abcd_commit_ready", {15'd0, load_ready}, 16'h0001);
        run_to(67);
        check("f2_digit0_d", {5'd0, display_out}, {5'd0, 11'b1110_1000010});

        // 8888 with digits 1 and 3 disabled.
        load_valid = 1'b1;
        load_data  = 16'h8888;
        step();
        load_valid = 1'b0;
        run_to(90);
        digit_en = 4'b0101;
        run_to(99);
        check("en_digit0_lit", {5'd0, display_out}, {5'd0, 11'b1110_0000000});
        run_to(107);
        check("en_digit1_blank", {5'd0, display_out}, {5'd0, 11'b1101_1111111});
        run_to(115);
        check("en_digit2_lit", {5'd0, display_out}, {5'd0, 11'b1011_0000000});
        run_to(123);
        check("en_digit3_blank", {5'd0, display_out}, {5'd0, 11'b0111_1111111});
        digit_en = 4'hF;

        // 0070: leading zeros blank only when suppression is built in.
        load_valid = 1'b1;
        load_data  = 16'h0070;
        step();
        load_valid = 1'b0;
        run_to(131);
        check("lz_digit0", {5'd0, display_out}, {5'd0, 11'b1110_0000001});
        run_to(139);
        check("lz_digit1", {5'd0, display_out}, {5'd0, 11'b1101_0001111});
        run_to(147);
`ifdef SEG_SCAN_LZ_BLANK_EN
        check("lz_digit2", {5'd0, display_out}, {5'd0, 11'b1011_1111111});
`else
        check("lz_digit2", {5'd0, display_out}, {5'd0, 11'b1011_0000001});
`endif
        run_to(155);
`ifdef SEG_SCAN_LZ_BLANK_EN
        check("lz_digit3", {5'd0, display_out}, {5'd0, 11'b0111_1111111});
`else
        check("lz_digit3", {5'd0, display_out}, {5'd0, 11'b0111_0000001});
`endif

        // Transfer on the frame-boundary edge: old value stays for one whole frame.
        run_to(159);
        load_valid = 1'b1;
        load_data  = 16'h5A5A;
        step();
        load_valid = 1'b0;
        check("bnd_xfer_taken", {15'd0, load_ready}, 16'h0000);
        run_to(163);
        check("bnd_old_digit0", {5'd0, display_out}, {5'd0, 11'b1110_0000001});
        run_to(171);
        check("bnd_old_digit1", {5'd0, display_out}, {5'd0, 11'b1101_0001111});
        run_to(191);
        check("bnd_still_pending", {15'd0, load_ready}, 16'h0000);
        step();
        check("bnd_commit_ready", {15'd0, load_ready}, 16'h0001);
        run_to(195);
        check("bnd_new_digit0", {5'd0, display_out}, {5'd0, 11'b1110_0001000});
        run_to(203);
        check("bnd_new_digit1", {5'd0, display_out}, {5'd0, 11'b1101_0100100});
        run_to(230);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
